// File: rtl/gdp_host_pkg.sv
// Shared types and constants for the GDP host driver slice.
// expected_sum() is used only when GDP_HOST_CHECK_EN is defined.
package gdp_host_pkg;

  localparam int DATA_W             = 8;
  localparam int START_CYCLES_DEF   = 2;
  localparam int RESTART_CYCLES_DEF = 2;
  localparam int TIMEOUT_CYCLES_DEF = 255;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    WAIT    = 3'd2,
    RESTART = 3'd3,
    RESP    = 3'd4
  } state_t;

  // Closed-form triangular number, truncated to the GDP result width.
  function automatic logic [DATA_W-1:0] expected_sum(input logic [DATA_W-1:0] n);
    logic [15:0] prod;
    prod = ({8'd0, n} * ({8'd0, n} + 16'd1)) >> 1'b1;
    return prod[DATA_W-1:0];
  endfunction

endpackage

// File: rtl/gdp_pulse_gen.sv
// Active-low pulse of CYCLES clocks on trigger; last flags the final low cycle.
module gdp_pulse_gen #(
  parameter int unsigned CYCLES = 2
) (
  input  logic clk,
  input  logic restart,
  input  logic trigger,
  output logic pulse_n,
  output logic last
);

  localparam logic [3:0] LOAD = 4'(CYCLES);

  logic [3:0] cnt_r;
  logic       pulse_n_r;

  // Down-counter: load on trigger, release the pin when the count expires.
  always_ff @(posedge clk) begin
    if (restart) begin
      cnt_r     <= 4'd0;
      pulse_n_r <= 1'b1;
    end else if (trigger) begin
      cnt_r     <= LOAD;
      pulse_n_r <= 1'b0;
    end else if (cnt_r == 4'd1) begin
      cnt_r     <= 4'd0;
      pulse_n_r <= 1'b1;
    end else if (cnt_r != 4'd0) begin
      cnt_r     <= cnt_r - 4'd1;
      pulse_n_r <= pulse_n_r;
    end else begin
      cnt_r     <= 4'd0;
      pulse_n_r <= 1'b1;
    end
  end

  assign pulse_n = pulse_n_r;
  assign last    = (cnt_r == 4'd1);

endmodule

// File: rtl/gdp_host_driver.sv
// Initiator for the GDP start/restart/done handshake with job/result valid-ready ports.
// Defining GDP_HOST_CHECK_EN adds the rsp_mismatch port and its reference check.
module gdp_host_driver
  import gdp_host_pkg::*;
#(
  parameter int unsigned START_CYCLES   = START_CYCLES_DEF,
  parameter int unsigned RESTART_CYCLES = RESTART_CYCLES_DEF,
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  parameter int unsigned TO_W           = 16
) (
  input  logic              clk,
  input  logic              restart,
  input  logic              req_valid,
  input  logic [DATA_W-1:0] req_n,
  output logic              req_ready,
  output logic              gdp_start_n,
  output logic              gdp_restart_n,
  output logic [DATA_W-1:0] gdp_n,
  input  logic [DATA_W-1:0] gdp_sum,
  input  logic              gdp_done,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_sum,
  output logic              rsp_timeout,
`ifdef GDP_HOST_CHECK_EN
  output logic              rsp_mismatch,
`endif
  input  logic              rsp_ready,
  output logic              busy
);

  localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT_CYCLES);
  localparam logic [TO_W-1:0] TO_ONE   = {{(TO_W-1){1'b0}}, 1'b1};
  localparam logic [TO_W-1:0] TO_MAX   = {TO_W{1'b1}};

  state_t            state_r, state_s;
  logic [DATA_W-1:0] gdp_n_r, gdp_n_s;
  logic [DATA_W-1:0] rsp_sum_r, rsp_sum_s;
  logic              rsp_timeout_r, rsp_timeout_s;
  logic              rsp_valid_r, rsp_valid_s;
  logic              req_ready_r, busy_r;
  logic [TO_W-1:0]   to_cnt_r, to_cnt_s, to_inc_s;
  logic              to_hit_s;
  logic              start_trig_s, restart_trig_s;
  logic              start_last_s, restart_last_s;

  // Saturating increment so a huge limit never wraps back to zero.
  assign to_inc_s = (to_cnt_r == TO_MAX) ? to_cnt_r : (to_cnt_r + TO_ONE);
  assign to_hit_s = (to_inc_s >= TO_LIMIT);

  gdp_pulse_gen #(.CYCLES(START_CYCLES)) u_start_pulse (
    .clk     (clk),
    .restart (restart),
    .trigger (start_trig_s),
    .pulse_n (gdp_start_n),
    .last    (start_last_s)
  );

  gdp_pulse_gen #(.CYCLES(RESTART_CYCLES)) u_restart_pulse (
    .clk     (clk),
    .restart (restart),
    .trigger (restart_trig_s),
    .pulse_n (gdp_restart_n),
    .last    (restart_last_s)
  );

  // Next-state and next-output values for the job sequencer.
  always_comb begin
    state_s        = state_r;
    gdp_n_s        = gdp_n_r;
    rsp_sum_s      = rsp_sum_r;
    rsp_timeout_s  = rsp_timeout_r;
    rsp_valid_s    = rsp_valid_r;
    to_cnt_s       = to_cnt_r;
    start_trig_s   = 1'b0;
    restart_trig_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (req_valid && req_ready_r) begin
          gdp_n_s      = req_n;
          start_trig_s = 1'b1;
          state_s      = START;
        end else begin
          state_s = IDLE;
        end
      end
      START: begin
        if (start_last_s) begin
          to_cnt_s = {TO_W{1'b0}};
          state_s  = WAIT;
        end else begin
          state_s = START;
        end
      end
      WAIT: begin
        to_cnt_s = to_inc_s;
        // done has priority over a timeout landing on the same cycle
        if (gdp_done) begin
          rsp_sum_s      = gdp_sum;
          rsp_timeout_s  = 1'b0;
          restart_trig_s = 1'b1;
          state_s        = RESTART;
        end else if (to_hit_s) begin
          rsp_sum_s      = {DATA_W{1'b0}};
          rsp_timeout_s  = 1'b1;
          restart_trig_s = 1'b1;
          state_s        = RESTART;
        end else begin
          state_s = WAIT;
        end
      end
      RESTART: begin
        if (restart_last_s) begin
          rsp_valid_s = 1'b1;
          state_s     = RESP;
        end else begin
          state_s = RESTART;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_s = 1'b0;
          to_cnt_s    = {TO_W{1'b0}};
          state_s     = IDLE;
        end else begin
          state_s = RESP;
        end
      end
      default: begin
        rsp_valid_s = 1'b0;
        state_s     = IDLE;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (restart) begin
      state_r       <= IDLE;
      gdp_n_r       <= {DATA_W{1'b0}};
      rsp_sum_r     <= {DATA_W{1'b0}};
      rsp_timeout_r <= 1'b0;
      rsp_valid_r   <= 1'b0;
      to_cnt_r      <= {TO_W{1'b0}};
      req_ready_r   <= 1'b1;
      busy_r        <= 1'b0;
    end else begin
      state_r       <= state_s;
      gdp_n_r       <= gdp_n_s;
      rsp_sum_r     <= rsp_sum_s;
      rsp_timeout_r <= rsp_timeout_s;
      rsp_valid_r   <= rsp_valid_s;
      to_cnt_r      <= to_cnt_s;
      req_ready_r   <= (state_s == IDLE);
      busy_r        <= (state_s != IDLE);
    end
  end

`ifdef GDP_HOST_CHECK_EN
  logic rsp_mismatch_r;

  // Compare the captured sum against the closed form; timeouts never flag.
  always_ff @(posedge clk) begin
    if (restart) begin
      rsp_mismatch_r <= 1'b0;
    end else if ((state_r == WAIT) && gdp_done) begin
      rsp_mismatch_r <= (gdp_sum != expected_sum(gdp_n_r));
    end else if ((state_r == WAIT) && to_hit_s) begin
      rsp_mismatch_r <= 1'b0;
    end else begin
      rsp_mismatch_r <= rsp_mismatch_r;
    end
  end

  assign rsp_mismatch = rsp_mismatch_r;
`endif

  assign req_ready   = req_ready_r;
  assign gdp_n       = gdp_n_r;
  assign rsp_valid   = rsp_valid_r;
  assign rsp_sum     = rsp_sum_r;
  assign rsp_timeout = rsp_timeout_r;
  assign busy        = busy_r;

endmodule

// File: tb/tb_gdp_host_driver.sv
// Scoreboard bench for gdp_host_driver with a behavioural GDP engine model.
module tb_gdp_host_driver;

  localparam int START_C   = 2;
  localparam int RESTART_C = 2;
  localparam int TIMEOUT_C = 20;

  logic       clk = 1'b0;
  logic       restart, req_valid, rsp_ready;
  logic [7:0] req_n;
  logic       req_ready, gdp_start_n, gdp_restart_n, rsp_valid, rsp_timeout, busy;
  logic [7:0] gdp_n, rsp_sum;
  logic [7:0] gdp_sum = 8'd0;
  logic       gdp_done = 1'b0;
`ifdef GDP_HOST_CHECK_EN
  logic       rsp_mismatch;
`endif

  always #5 clk = ~clk;

  gdp_host_driver #(
    .START_CYCLES   (START_C),
    .RESTART_CYCLES (RESTART_C),
    .TIMEOUT_CYCLES (TIMEOUT_C),
    .TO_W           (16)
  ) dut (
    .clk           (clk),
    .restart       (restart),
    .req_valid     (req_valid),
    .req_n         (req_n),
    .req_ready     (req_ready),
    .gdp_start_n   (gdp_start_n),
    .gdp_restart_n (gdp_restart_n),
    .gdp_n         (gdp_n),
    .gdp_sum       (gdp_sum),
    .gdp_done      (gdp_done),
    .rsp_valid     (rsp_valid),
    .rsp_sum       (rsp_sum),
    .rsp_timeout   (rsp_timeout),
`ifdef GDP_HOST_CHECK_EN
    .rsp_mismatch  (rsp_mismatch),
`endif
    .rsp_ready     (rsp_ready),
    .busy          (busy)
  );

  typedef struct {
    logic [7:0] sum;
    logic       to;
    logic       mm;
    int         lat;
  } exp_t;

  exp_t       sb_q[$];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         model_delay = 0;
  logic [7:0] model_sum = 8'd0;
  logic       stray = 1'b0;
  logic [7:0] exp_gdp_n = 8'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  // GDP engine model plus response monitor, all sampled on the falling edge.
  initial begin : model_and_monitor
    bit armed = 1'b0;
    bit vprev = 1'b0;
    bit ready_next = 1'b0;
    int wcnt = 0;
    int s_len = 0;
    int r_len = 0;
    int release_cyc = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (restart) begin
        armed = 1'b0; gdp_done = 1'b0; s_len = 0; r_len = 0; vprev = 1'b0; ready_next = 1'b0;
      end else begin
        if (!gdp_start_n) s_len++;
        else if (s_len != 0) begin
          chk("start_pulse_len", s_len, START_C);
          s_len = 0;
          release_cyc = cyc;
        end
        if (!gdp_restart_n) r_len++;
        else if (r_len != 0) begin
          chk("restart_pulse_len", r_len, RESTART_C);
          r_len = 0;
        end
        if (stray) gdp_done = 1'b1;
        else if (!gdp_start_n) begin armed = 1'b1; wcnt = 0; gdp_done = 1'b0; end
        else if (!gdp_restart_n) begin armed = 1'b0; gdp_done = 1'b0; end
        else if (armed) begin
          wcnt++;
          if (model_delay != 0 && wcnt >= model_delay) begin
            gdp_done = 1'b1;
            gdp_sum  = model_sum;
          end
        end else gdp_done = 1'b0;

        chk("gdp_n_stable", gdp_n, exp_gdp_n);
        if (ready_next) begin
          chk("req_ready_after_rsp", req_ready, 1'b1);
          chk("rsp_valid_dropped", rsp_valid, 1'b0);
          chk("busy_after_rsp", busy, 1'b0);
          ready_next = 1'b0;
        end
        if (rsp_valid) begin
          if (sb_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_rsp actual=valid sum=%0d required=no response", rsp_sum);
          end else begin
            chk("rsp_sum", rsp_sum, sb_q[0].sum);
            chk("rsp_timeout", rsp_timeout, sb_q[0].to);
`ifdef GDP_HOST_CHECK_EN
            chk("rsp_mismatch", rsp_mismatch, sb_q[0].mm);
`endif
            chk("busy_in_resp", busy, 1'b1);
            if (!vprev) chk("rsp_latency", cyc - release_cyc, sb_q[0].lat);
            if (rsp_ready) begin
              void'(sb_q.pop_front());
              ready_next = 1'b1;
            end
          end
        end
        vprev = rsp_valid;
      end
    end
  end

  task automatic check_reset_vals(input string tag);
    chk({tag, "_req_ready"}, req_ready, 1'b1);
    chk({tag, "_start_n"}, gdp_start_n, 1'b1);
    chk({tag, "_restart_n"}, gdp_restart_n, 1'b1);
    chk({tag, "_gdp_n"}, gdp_n, 8'd0);
    chk({tag, "_rsp_valid"}, rsp_valid, 1'b0);
    chk({tag, "_rsp_sum"}, rsp_sum, 8'd0);
    chk({tag, "_rsp_timeout"}, rsp_timeout, 1'b0);
    chk({tag, "_busy"}, busy, 1'b0);
  endtask

  // Offer a job and hold it until the bench sees it accepted.
  task automatic issue(input logic [7:0] n);
    int b = 0;
    req_valid = 1'b1;
    req_n     = n;
    @(negedge clk);
    while (!req_ready && b < 200) begin @(negedge clk); b++; end
    if (!req_ready) begin
      checks++; errors++;
      $display("FAIL accept_wait actual=req_ready low required=accept within 200 cycles");
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    exp_gdp_n = n;
    req_n     = 8'($urandom);
  endtask

  // Full job: reference outcome pushed first, then request, wait, backpressure, accept.
  task automatic run_job(input logic [7:0] n, input int delay, input logic [7:0] sum, input int hold);
    exp_t e;
    int   b = 0;
    int   tri_n;
    bit   done_ok;
    done_ok = (delay != 0) && (delay <= TIMEOUT_C);
    tri_n   = (int'(n) * (int'(n) + 1) / 2) % 256;
    e.to    = !done_ok;
    e.sum   = done_ok ? sum : 8'd0;
    e.mm    = done_ok && (int'(sum) != tri_n);
    e.lat   = (done_ok ? delay : TIMEOUT_C) + RESTART_C;
    model_delay = delay;
    model_sum   = sum;
    sb_q.push_back(e);
    issue(n);
    while (!rsp_valid && b < 300) begin @(negedge clk); b++; end
    if (!rsp_valid) begin
      checks++; errors++;
      $display("FAIL rsp_wait actual=no rsp_valid required=response within 300 cycles");
    end
    repeat (hold) @(negedge clk);
    @(posedge clk); #1 rsp_ready = 1'b1;
    @(posedge clk); #1 rsp_ready = 1'b0;
  endtask

  initial begin : stimulus
    int n;
    int d;
    int s;
    restart   = 1'b1;
    req_valid = 1'b0;
    req_n     = 8'd0;
    rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 restart = 1'b0;
    @(negedge clk);
    check_reset_vals("reset");

    @(posedge clk); #1;
    run_job(8'd5, 6, 8'd15, 0);
    run_job(8'd8, 3, 8'h24, 10);
    run_job(8'd7, 0, 8'd0, 1);
    run_job(8'd10, 20, 8'h37, 0);
    run_job(8'd4, 21, 8'h0a, 2);

    // done high while idle must not start anything
    stray = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("stray_done_busy", busy, 1'b0);
    chk("stray_done_ready", req_ready, 1'b1);
    stray = 1'b0;
    @(negedge clk);
    @(posedge clk); #1;

    model_delay = 0;
    issue(8'd9);
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("mid_wait_busy", busy, 1'b1);
    @(posedge clk); #1 restart = 1'b1;
    @(posedge clk); #1 restart = 1'b0;
    sb_q.delete();
    exp_gdp_n = 8'd0;
    @(negedge clk);
    check_reset_vals("midjob");
    @(posedge clk); #1;
    run_job(8'd3, 4, 8'd6, 0);

    run_job(8'd10, 5, 8'd56, 0);
    run_job(8'd10, 5, 8'd55, 1);

    for (int i = 0; i < 20; i++) begin
      n = $urandom_range(0, 255);
      d = $urandom_range(0, 24);
      s = ($urandom_range(0, 1) == 0) ? ((n * (n + 1) / 2) % 256) : $urandom_range(0, 255);
      run_job(8'(n), d, 8'(s), $urandom_range(0, 3));
    end

    repeat (4) @(negedge clk);
    if (sb_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL sb_drain actual=%0d pending required=0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog actual=still running required=finish before 40000 cycles");
    $fatal(1, "watchdog expired");
  end

endmodule
